mem_sram_controller: RTL and testbench

- Sequences MEM-stage loads/stores from the EXE/MEM pipeline register onto an external 16-bit asynchronous SRAM.
- Each 32-bit access is split into two 16-bit half-word phases.
- Drives `ready` low while an access is in flight. The top level uses `~ready` as the `freeze` input of all pipeline registers and the PC.
- Sits between the MEM stage and the board SRAM pins; replaces the single-cycle data memory.

---
 rtl/sram_pkg.sv | 17 +
 rtl/mem_sram_controller_if.sv | 27 ++
 rtl/sram_phase_counter.sv | 26 ++
 rtl/mem_sram_controller.sv | 101 ++++++++++
 tb/tb_mem_sram_controller.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared state encoding and defaults for the MEM-stage SRAM controller.
// Two-bit states are plain localparams so older netlists and probes still decode them.
package sram_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int unsigned DEF_BASE_ADDR = 1024;
   localparam int unsigned SRAM_DW       = 16;
   localparam int unsigned CNT_W         = 4;

   typedef struct packed {
      logic        wr;
      logic [31:0] data;
   } req_t;
endpackage

// File: rtl/mem_sram_controller_if.sv
// Pipeline-side request bus plus board SRAM pins; slave = controller, master = pipeline/pad side.
// No flow control beyond ready: the pipeline freezes on ~ready.
interface mem_sram_controller_if #(parameter int unsigned SRAM_AW = 18);
   import sram_pkg::*;

   logic                 rd_en;
   logic                 wr_en;
   logic [31:0]          address;
   logic [31:0]          write_data;
   logic [31:0]          read_data;
   logic                 ready;
   logic [SRAM_AW-1:0]   sram_addr;
   logic [SRAM_DW-1:0]   sram_dq_o;
   logic [SRAM_DW-1:0]   sram_dq_i;
   logic                 sram_dq_oe;
   logic                 sram_we_n;

   modport slave (
      input  rd_en, wr_en, address, write_data, sram_dq_i,
      output read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
   );

   modport master (
      output rd_en, wr_en, address, write_data, sram_dq_i,
      input  read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_phase_counter.sv
// Counts the wait cycles of one half-word phase; last is high on the final cycle, then it wraps to 0.
// Zero latency on last; clr holds the count at 0 while no phase is running.
module sram_phase_counter
   import sram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic last
);
   logic [CNT_W-1:0] count;

   assign last = (count == CNT_W'(WAIT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         count <= '0;
      end else if (last) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/mem_sram_controller.sv
// Splits each 32-bit MEM load/store into low then high 16-bit SRAM phases of WAIT_CYCLES each.
// ready is low for 2*WAIT_CYCLES+1 cycles per access and high for one DONE cycle; the pipeline freezes on ~ready.
module mem_sram_controller
   import sram_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   mem_sram_controller_if.slave   bus
);
   logic [1:0]          state;
   req_t                req;
   logic [SRAM_AW-2:0]  req_word;
   logic                req_any;
   logic [31:0]         offset;
   logic [SRAM_AW-2:0]  word_idx;
   logic                phase_last;
   logic                phase_clr;

   logic [31:0]         read_data;
   logic [SRAM_AW-1:0]  sram_addr;
   logic [SRAM_DW-1:0]  sram_dq_o;
   logic                sram_dq_oe;
   logic                sram_we_n;

   assign req_any = bus.rd_en | bus.wr_en;
   assign offset  = bus.address - 32'(BASE_ADDR);
   // Dropping the upper offset bits makes out-of-range addresses wrap around the SRAM.
   assign word_idx = (SRAM_AW-1)'(offset >> 2);

   assign phase_clr = (state == ST_IDLE) || (state == ST_DONE);

   sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_phase_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (phase_clr),
      .last (phase_last)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         req        <= '0;
         req_word   <= '0;
         read_data  <= '0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_we_n  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_any) begin
                  req.wr     <= bus.wr_en;
                  req.data   <= bus.write_data;
                  req_word   <= word_idx;
                  sram_addr  <= {word_idx, 1'b0};
                  sram_dq_o  <= bus.write_data[15:0];
                  sram_dq_oe <= bus.wr_en;
                  sram_we_n  <= ~bus.wr_en;
                  state      <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (phase_last) begin
                  if (!req.wr) begin
                     read_data[15:0] <= bus.sram_dq_i;
                  end
                  sram_addr <= {req_word, 1'b1};
                  sram_dq_o <= req.data[31:16];
                  state     <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (phase_last) begin
                  if (!req.wr) begin
                     read_data[31:16] <= bus.sram_dq_i;
                  end
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            default: begin
               // The pipeline advances on this edge; any request still visible belongs to the finished access.
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready      = (state == ST_IDLE) ? ~req_any : (state == ST_DONE);
   assign bus.read_data  = read_data;
   assign bus.sram_addr  = sram_addr;
   assign bus.sram_dq_o  = sram_dq_o;
   assign bus.sram_dq_oe = sram_dq_oe;
   assign bus.sram_we_n  = sram_we_n;
endmodule

// File: tb/tb_mem_sram_controller.sv
// Directed bench: drives loads/stores through the controller into a pin-level SRAM model and scoreboards read_data.
module tb_mem_sram_controller;
   import sram_pkg::*;

   localparam int W = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_sram_controller_if #(.SRAM_AW(18)) bus  ();
   mem_sram_controller_if #(.SRAM_AW(18)) bus1 ();

   mem_sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   mem_sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   logic [15:0] sram [0:63];
   always @(posedge clk) begin
      if (!bus.sram_we_n && bus.sram_dq_oe) sram[bus.sram_addr[5:0]] <= bus.sram_dq_o;
   end
   assign bus.sram_dq_i  = sram[bus.sram_addr[5:0]];
   assign bus1.sram_dq_i = 16'hC3C3;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb_q [$];
   logic [15:0] exp_mem [int];
   logic [31:0] last_rd = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // Presents one request in the current IDLE cycle and checks every cycle up to and including DONE.
   task automatic do_access(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input int wrd, input bit hold);
      logic [31:0] exp_rd;
      logic        hi;
      logic [17:0] exp_addr;
      if (wr) begin
         exp_mem[2*wrd]   = data[15:0];
         exp_mem[2*wrd+1] = data[31:16];
         exp_rd = last_rd;
      end else begin
         exp_rd  = {exp_mem[2*wrd+1], exp_mem[2*wrd]};
         last_rd = exp_rd;
      end
      sb_q.push_back(exp_rd);
      bus.rd_en = rd;
      bus.wr_en = wr;
      bus.address = addr;
      bus.write_data = data;
      #1;
      chk({tag, "_rdy_c0"}, 32'(bus.ready), 32'd0);
      for (int c = 1; c <= 2*W; c++) begin
         tick;
         if (c == 1 && !hold) begin
            bus.rd_en = 1'b0;
            bus.wr_en = 1'b0;
            bus.address = 32'hFFFF_FFFC;
            bus.write_data = 32'h0;
            #1;
         end
         hi = (c > W);
         exp_addr = 18'(2*wrd) | 18'(hi);
         chk($sformatf("%s_addr_c%0d", tag, c), 32'(bus.sram_addr), 32'(exp_addr));
         chk($sformatf("%s_rdy_c%0d", tag, c), 32'(bus.ready), 32'd0);
         chk($sformatf("%s_wen_c%0d", tag, c), 32'(bus.sram_we_n), 32'(!wr));
         chk($sformatf("%s_oe_c%0d", tag, c), 32'(bus.sram_dq_oe), 32'(wr));
         if (wr) chk($sformatf("%s_dq_c%0d", tag, c), 32'(bus.sram_dq_o), hi ? 32'(data[31:16]) : 32'(data[15:0]));
      end
      tick;
      chk({tag, "_rdy_done"}, 32'(bus.ready), 32'd1);
      chk({tag, "_wen_done"}, 32'(bus.sram_we_n), 32'd1);
      chk({tag, "_oe_done"}, 32'(bus.sram_dq_oe), 32'd0);
      chk({tag, "_rdata"}, bus.read_data, sb_q.pop_front());
      tick;
      if (!hold) chk({tag, "_rdy_idle"}, 32'(bus.ready), 32'd1);
   endtask

   initial begin
      bus.rd_en = 1'b0;  bus.wr_en = 1'b0;  bus.address = 32'h0;  bus.write_data = 32'h0;
      bus1.rd_en = 1'b0; bus1.wr_en = 1'b0; bus1.address = 32'h0; bus1.write_data = 32'h0;
      tick; tick; tick;
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_wen", 32'(bus.sram_we_n), 32'd1);
      chk("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("rst_rdata", bus.read_data, 32'd0);
      chk("rst_addr", 32'(bus.sram_addr), 32'd0);
      chk("rst_dq", 32'(bus.sram_dq_o), 32'd0);
      rst = 1'b1;
      tick;

      do_access("st1", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 2, 1'b0);
      do_access("ld1", 1'b1, 1'b0, 32'd1032, 32'h0, 2, 1'b0);
      do_access("st2", 1'b0, 1'b1, 32'd1032, 32'h56781234, 2, 1'b0);
      do_access("ld2", 1'b1, 1'b0, 32'd1032, 32'h0, 2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk($sformatf("hold_rdata_%0d", i), bus.read_data, 32'h56781234);
      end
      do_access("st3", 1'b0, 1'b1, 32'd1024, 32'hA5A55A5A, 0, 1'b0);
      chk("st3_rdata_kept", bus.read_data, 32'h56781234);

      // rd_en and wr_en together is a store; the low address bits are ignored.
      do_access("both", 1'b1, 1'b1, 32'd1027, 32'h0BADF00D, 0, 1'b0);
      do_access("ld3", 1'b1, 1'b0, 32'd1024, 32'h0, 0, 1'b0);

      do_access("b2b_st", 1'b0, 1'b1, 32'd1036, 32'h13579BDF, 3, 1'b1);
      do_access("b2b_ld", 1'b1, 1'b0, 32'd1036, 32'h0, 3, 1'b1);
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      tick;
      chk("b2b_idle", 32'(bus.ready), 32'd1);

      do_access("wrap", 1'b1, 1'b0, 32'd525312, 32'h0, 0, 1'b0);

      bus1.rd_en = 1'b1;
      bus1.address = 32'd1024;
      #1;
      chk("w1_rdy_c0", 32'(bus1.ready), 32'd0);
      tick;
      bus1.rd_en = 1'b0;
      chk("w1_rdy_c1", 32'(bus1.ready), 32'd0);
      chk("w1_addr_c1", 32'(bus1.sram_addr), 32'd0);
      tick;
      chk("w1_rdy_c2", 32'(bus1.ready), 32'd0);
      chk("w1_addr_c2", 32'(bus1.sram_addr), 32'd1);
      tick;
      chk("w1_rdy_c3", 32'(bus1.ready), 32'd1);
      chk("w1_rdata", bus1.read_data, 32'hC3C3C3C3);
      tick;
      chk("w1_rdy_c4", 32'(bus1.ready), 32'd1);

      // Reset on the second LOW cycle of a store must abandon it.
      bus.wr_en = 1'b1;
      bus.address = 32'd1024;
      bus.write_data = 32'hFFFF0000;
      tick;
      tick;
      rst = 1'b0;
      bus.wr_en = 1'b0;
      tick;
      chk("mrst_wen", 32'(bus.sram_we_n), 32'd1);
      chk("mrst_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("mrst_rdata", bus.read_data, 32'd0);
      chk("mrst_ready", 32'(bus.ready), 32'd1);
      chk("mrst_addr", 32'(bus.sram_addr), 32'd0);
      rst = 1'b1;
      last_rd = 32'h0;
      tick;
      do_access("post_rst", 1'b1, 1'b0, 32'd1036, 32'h0, 3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
